// File: rtl/noc_pkg.sv
// Shared router definitions: flit types, port indices, widths and allocator state encoding.
package noc_pkg;
  localparam int NREQ       = 5;
  localparam int LEN_W      = 12;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of elig scanning from ptr+1 upward, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_pick #(
  parameter int NREQ  = 5,
  parameter int PTR_W = 3
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic             vld
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    win = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NREQ);
      if (!vld && elig[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_allocator.sv
// Wormhole allocator for one output port: round-robin on headers, path locked for the whole packet.
// Grant is combinational in the cycle dcts and the owner's req are both high; either low stalls the packet.
module output_port_allocator #(
  parameter int NREQ  = noc_pkg::NREQ,
  parameter int LEN_W = noc_pkg::LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     flit_id,
  input  logic [LEN_W*NREQ-1:0] length,
  input  logic                  dcts,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       sel,
  output logic                  busy,
  output logic                  err
);
  import noc_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] ptr;
  logic [LEN_W-1:0] remaining;
  logic             long_pkt;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win;
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  logic [LEN_W-1:0] win_len;
  logic [2:0]       own_flit;
  logic             xfer;
  logic             last_xfer;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && (flit_id[3*i +: 3] == FLIT_HEADER);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .elig(elig),
    .ptr (ptr),
    .win (win),
    .vld (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  assign win_len  = length[LEN_W*win_idx +: LEN_W];
  assign own_flit = flit_id[3*owner +: 3];

  // Reset gates the grant combinationally so a mid-packet reset never pops a FIFO.
  assign xfer      = rst && (state == ST_LOCKED) && dcts && req[owner];
  assign last_xfer = xfer && (remaining == LEN_W'(1));
  assign grant     = xfer ? sel : '0;
  assign busy      = (state == ST_LOCKED);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_vld)   state_nxt = ST_LOCKED;
      ST_LOCKED: if (last_xfer) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sel       <= '0;
      owner     <= '0;
      ptr       <= PTR_W'(NREQ - 1);
      remaining <= '0;
      long_pkt  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && win_vld) begin
        sel      <= win;
        owner    <= win_idx;
        long_pkt <= (win_len > LEN_W'(1));
        if (win_len == '0) begin
          remaining <= LEN_W'(1);
          err       <= 1'b1;
        end else begin
          remaining <= win_len;
        end
      end else if (xfer) begin
        // Length field is authoritative; flit-type mismatches are only flagged.
        if (own_flit == FLIT_TAIL && remaining > LEN_W'(1)) err <= 1'b1;
        if (own_flit != FLIT_TAIL && remaining == LEN_W'(1) && long_pkt) err <= 1'b1;
        remaining <= remaining - LEN_W'(1);
        if (last_xfer) begin
          sel <= '0;
          ptr <= owner;
        end
      end
    end
  end
endmodule

// File: tb/tb_output_port_allocator.sv
// Bench: input FIFOs modelled as queues of flits, a packet-level reference allocator, and directed scenarios.
module tb_output_port_allocator;
  import noc_pkg::*;

  localparam int N = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [3*N-1:0]      flit_id;
  logic [LEN_W*N-1:0]  length;
  logic                dcts;
  logic [N-1:0]        grant;
  logic [N-1:0]        sel;
  logic                busy;
  logic                err;

  output_port_allocator #(.NREQ(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .dcts(dcts), .grant(grant), .sel(sel), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Each queue entry is {flit type, length field}.
  logic [14:0] q [N][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0] gnt_log [64];
  logic [N-1:0] sel_log [64];
  logic         busy_log[64];
  logic         err_log [64];

  // Reference allocator state: locked owner, flits still owed, round-robin pointer.
  bit m_lock  = 1'b0;
  bit m_err   = 1'b0;
  bit m_long  = 1'b0;
  int m_owner = 0;
  int m_ptr   = N - 1;
  int m_rem   = 0;

  int           dcts_mode = 0;
  bit           dcts_pat[64];
  int           drop_pct  = 0;
  logic [N-1:0] drop      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs;
    logic [14:0] h;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        h = q[i][0];
        req[i] = !drop[i];
        flit_id[3*i +: 3] = h[14:12];
        length[LEN_W*i +: LEN_W] = h[11:0];
      end else begin
        req[i] = 1'b0;
        flit_id[3*i +: 3] = FLIT_BODY;
        length[LEN_W*i +: LEN_W] = '0;
      end
    end
    case (dcts_mode)
      0:       dcts = 1'b1;
      1:       dcts = ($urandom_range(0, 3) != 0);
      default: dcts = dcts_pat[(cyc < 64) ? cyc : 63];
    endcase
  endtask

  task automatic push_pkt(input int i, input int len, input bit corrupt);
    int n;
    logic [2:0] typ;
    logic [11:0] lf;
    n = (len == 0) ? 1 : len;
    for (int k = 0; k < n; k++) begin
      typ = (k == 0) ? FLIT_HEADER : ((k == n - 1) ? FLIT_TAIL : FLIT_BODY);
      if (corrupt && k == 1) typ = FLIT_TAIL;
      lf = (k == 0) ? 12'(len) : 12'd0;
      q[i].push_back({typ, lf});
    end
  endtask

  // One cycle: compare at the falling edge, advance the model, pop and re-drive after the rising edge.
  task automatic tick;
    logic [N-1:0] e_sel, e_gnt;
    logic [2:0]   typ;
    int           pop_i, j, len;
    bit           found;
    @(negedge clk);
    e_sel = m_lock ? N'(1 << m_owner) : N'(0);
    e_gnt = (rst && m_lock && dcts && req[m_owner]) ? e_sel : N'(0);
    check("grant", 32'(grant), 32'(e_gnt));
    check("sel",   32'(sel),   32'(e_sel));
    check("busy",  32'(busy),  32'(m_lock));
    check("err",   32'(err),   32'(m_err));
    if (cyc < 64) begin
      gnt_log[cyc]  = grant;
      sel_log[cyc]  = sel;
      busy_log[cyc] = busy;
      err_log[cyc]  = err;
    end
    pop_i = -1;
    if (!rst) begin
      m_lock = 1'b0; m_err = 1'b0; m_ptr = N - 1; m_rem = 0;
    end else if (!m_lock) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && req[j] && flit_id[3*j +: 3] == FLIT_HEADER) begin
          found   = 1'b1;
          len     = int'(length[LEN_W*j +: LEN_W]);
          m_lock  = 1'b1;
          m_owner = j;
          m_rem   = (len == 0) ? 1 : len;
          m_long  = (len >= 2);
          if (len == 0) m_err = 1'b1;
        end
      end
    end else if (e_gnt != 0) begin
      typ = flit_id[3*m_owner +: 3];
      if (typ == FLIT_TAIL && m_rem > 1) m_err = 1'b1;
      if (typ != FLIT_TAIL && m_rem == 1 && m_long) m_err = 1'b1;
      pop_i = m_owner;
      if (m_rem == 1) begin
        m_lock = 1'b0;
        m_ptr  = m_owner;
      end
      m_rem--;
    end
    @(posedge clk);
    #1;
    if (pop_i >= 0) void'(q[pop_i].pop_front());
    cyc++;
    for (int i = 0; i < N; i++) drop[i] = ($urandom_range(0, 99) < drop_pct);
    drive_inputs();
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drop_pct = 0;
    drop = '0;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_inputs();
    tick();
    tick();
    check("rst_sel",  32'(sel),  32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err",  32'(err),  32'(0));
    rst = 1'b1;
    cyc = 0;
    drive_inputs();
  endtask

  function automatic int ngr(input logic [N-1:0] m, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (gnt_log[k] == m) c++;
    return c;
  endfunction

  initial begin
    int r, len, pend;
    rst = 1'b0; req = '0; flit_id = '0; length = '0; dcts = 1'b0;
    for (int k = 0; k < 64; k++) dcts_pat[k] = 1'b1;

    // Single packet on N, length 3.
    do_reset();
    dcts_mode = 0;
    push_pkt(P_N, 3, 1'b0);
    drive_inputs();
    repeat (6) tick();
    check("s1_sel_t",   32'(sel_log[0]), 32'(0));
    check("s1_sel_t1",  32'(sel_log[1]), 32'(5'b00010));
    check("s1_gnt_t1",  32'(gnt_log[1]), 32'(5'b00010));
    check("s1_gnt_t3",  32'(gnt_log[3]), 32'(5'b00010));
    check("s1_ngrants", 32'(ngr(5'b00010, 0, 5)), 32'(3));
    check("s1_busy_t4", 32'(busy_log[4]), 32'(0));
    check("s1_sel_t4",  32'(sel_log[4]), 32'(0));
    check("s1_err",     32'(err_log[4]), 32'(0));

    // Round-robin among L, E, S with length-2 packets.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      push_pkt(P_L, 2, 1'b0); push_pkt(P_E, 2, 1'b0); push_pkt(P_S, 2, 1'b0);
    end
    drive_inputs();
    repeat (14) tick();
    check("rr_1st",   32'(gnt_log[1]),  32'(5'b00001));
    check("rr_bub1",  32'(gnt_log[3]),  32'(0));
    check("rr_2nd",   32'(gnt_log[4]),  32'(5'b00100));
    check("rr_bub2",  32'(gnt_log[6]),  32'(0));
    check("rr_3rd",   32'(gnt_log[7]),  32'(5'b10000));
    check("rr_bub3",  32'(gnt_log[9]),  32'(0));
    check("rr_4th",   32'(gnt_log[10]), 32'(5'b00001));

    // Backpressure on E, length 4, dcts 1,0,0,1,1,1.
    do_reset();
    dcts_mode = 2;
    dcts_pat[1] = 1; dcts_pat[2] = 0; dcts_pat[3] = 0;
    dcts_pat[4] = 1; dcts_pat[5] = 1; dcts_pat[6] = 1;
    push_pkt(P_E, 4, 1'b0);
    drive_inputs();
    repeat (10) tick();
    check("bp_ngrants", 32'(ngr(5'b00100, 0, 9)), 32'(4));
    check("bp_stall2",  32'(gnt_log[2]), 32'(0));
    check("bp_stall3",  32'(gnt_log[3]), 32'(0));
    check("bp_sel2",    32'(sel_log[2]), 32'(5'b00100));
    check("bp_sel3",    32'(sel_log[3]), 32'(5'b00100));
    check("bp_last",    32'(gnt_log[6]), 32'(5'b00100));
    check("bp_rel",     32'(busy_log[7]), 32'(0));
    dcts_mode = 0;

    // Reset after 2 of 5 flits on W, then L and S contend.
    do_reset();
    push_pkt(P_W, 5, 1'b0);
    drive_inputs();
    repeat (3) tick();
    rst = 1'b0;
    drive_inputs();
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    push_pkt(P_L, 1, 1'b0);
    push_pkt(P_S, 1, 1'b0);
    drive_inputs();
    repeat (4) tick();
    check("rm_gnt2",  32'(gnt_log[2]), 32'(5'b01000));
    check("rm_gnt3",  32'(gnt_log[3]), 32'(0));
    check("rm_sel3",  32'(sel_log[3]), 32'(5'b01000));
    check("rm_sel4",  32'(sel_log[4]), 32'(0));
    check("rm_busy4", 32'(busy_log[4]), 32'(0));
    check("rm_L",     32'(gnt_log[5]), 32'(5'b00001));
    check("rm_S",     32'(gnt_log[7]), 32'(5'b10000));

    // Early tail inside a length-3 packet.
    do_reset();
    push_pkt(P_N, 3, 1'b1);
    drive_inputs();
    repeat (8) tick();
    check("e1_err2",    32'(err_log[2]), 32'(0));
    check("e1_err3",    32'(err_log[3]), 32'(1));
    check("e1_ngrants", 32'(ngr(5'b00010, 0, 7)), 32'(3));
    check("e1_rel",     32'(busy_log[4]), 32'(0));
    check("e1_sticky",  32'(err_log[7]), 32'(1));

    // Zero-length header.
    do_reset();
    push_pkt(P_E, 0, 1'b0);
    drive_inputs();
    repeat (4) tick();
    check("e0_err0",    32'(err_log[0]), 32'(0));
    check("e0_err1",    32'(err_log[1]), 32'(1));
    check("e0_gnt1",    32'(gnt_log[1]), 32'(5'b00100));
    check("e0_gnt2",    32'(gnt_log[2]), 32'(0));
    check("e0_busy2",   32'(busy_log[2]), 32'(0));
    check("e0_ngrants", 32'(ngr(5'b00100, 0, 3)), 32'(1));

    // Randomized traffic, backpressure and request gaps.
    do_reset();
    dcts_mode = 1;
    drop_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 19);
          len = (r == 0) ? 0 : $urandom_range(1, 6);
          push_pkt(i, len, (r == 1));
        end
      end
      drive_inputs();
      tick();
    end
    drop_pct = 0;
    dcts_mode = 0;
    drive_inputs();
    pend = 1;
    for (int c = 0; c < 600 && pend != 0; c++) begin
      tick();
      pend = m_lock ? 1 : 0;
      for (int i = 0; i < N; i++) pend += q[i].size();
    end
    check("drain", 32'(pend), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Packet-granular (wormhole) allocator for one router output port. It arbitrates among the five input ports (L, N, E, W, S) round-robin on header flits and locks the crossbar path to the winner for the whole packet. It paces flit transfers against the downstream clear-to-send, then releases the port. One instance per output port sits between the per-input LBDR/flow-control requests and the input FIFO read enables and crossbar selects.

## Interface
- NREQ, 5, number of requesting input ports; index 0=L, 1=N, 2=E, 3=W, 4=S
- LEN_W, 12, width of the header length field (total flits in packet, header included)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  input i has a nonempty FIFO routed to this output
- flit_id  in  3*NREQ  flit type of the head flit of input i, slice [3i+2:3i]
- length  in  LEN_W*NREQ  length field of the head flit of input i, slice [LEN_W*i +: LEN_W]
- dcts  in  1  downstream can accept a flit this cycle
- grant  out  NREQ  one-hot; FIFO read enable of the owner; a flit transfers this cycle
- sel  out  NREQ  one-hot crossbar select; held for the whole packet; 0 when idle
- busy  out  1  port locked to an owner
- err  out  1  sticky protocol error flag

## Operation
- Two states: IDLE and LOCKED.
- IDLE:
  - Eligible inputs satisfy req[i] && flit_id[i]==FLIT_HEADER.
  - If any input is eligible, pick the first eligible input scanning from ptr+1 upward, wrapping modulo NREQ.
  - At the next edge: sel←onehot(winner), owner←winner, remaining←length[winner], state←LOCKED.
  - A length of 0 is loaded as 1 and sets err.
  - Non-header heads are ignored in IDLE.
- LOCKED:
  - grant = sel when dcts && req[owner]; otherwise 0. grant is combinational.
  - Each grant decrements remaining by 1.
  - If remaining==1 at a grant, at the next edge: state←IDLE, sel←0, ptr←owner.
- Error checks on each grant, setting err:
  - granted flit is FLIT_TAIL while remaining>1, or
  - granted flit is not FLIT_TAIL while remaining==1 and the loaded length was ≥2.
  - Errors do not alter sequencing; length is authoritative.
- Requests from non-owner inputs during LOCKED are ignored. Arbitration is never pre-empted.
- err clears only on reset.

## Timing
- Reset, while rst==0 at an edge: state=IDLE, sel=0, busy=0, err=0, remaining=0, ptr=NREQ-1 (input 0 has first priority).
- grant is forced to 0 combinationally while rst==0, including reset asserted mid-packet.
- Header visible at cycle t: sel/busy high from t+1. First grant at t+1 at the earliest, when dcts=1.
- Flit throughput in LOCKED: one flit per cycle while dcts && req[owner].
  - Either signal low stalls the packet with no grant.
  - remaining, sel and the lock are held during a stall.
- Last grant at cycle u: sel=0 and busy=0 at u+1. That IDLE cycle arbitrates, and the next owner's sel is valid at u+2. This is a mandatory one-cycle bubble between packets.
- Length-1 packet: single grant, then release.
- remaining is LEN_W bits and never underflows; release occurs at 1.

## Structure
- Shared package noc_pkg holds:
  - FLIT_HEADER=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100
  - port indices P_L..P_S
  - DATA_WIDTH=32
  - LEN_W default
  - state encoding
- Sub-module rr_pick: purely combinational rotate-priority picker. Inputs: NREQ-bit eligible vector and ptr. Outputs: one-hot winner and a valid flag.
- The top level holds the state register, owner/ptr, the remaining counter and the err logic.

## Test plan
- Single packet, no contention: header on N (index 1) with length 3, dcts=1 throughout. Expect sel=00010 at t+1; grant=00010 at t+1..t+3; busy=0 and sel=0 at t+4; err=0.
- Round-robin fairness: L, E and S (indices 0, 2, 4) hold length-2 headers continuously after reset. Expect grant order L, E, S, L, with a one-cycle bubble between packets.
- Backpressure: owner E with length 4 and dcts toggling 1,0,0,1,1,1. Expect grants only on dcts=1 cycles, 4 grants total, and sel held stable through the stalls.
- Reset mid-packet: drive rst=0 after 2 of 5 flits. Expect grant=0 immediately. After the edge: sel=0, busy=0, ptr=4; the next arbitration favours L.
- Protocol errors:
  - Length-3 packet whose second flit is FLIT_TAIL: expect err=1 from the next cycle, all 3 grants still issued, and err staying 1 until reset.
  - Header with length=0: expect one grant, release, and err=1.
